// File: rtl/subband_frame_serializer_if.sv
// Stream-side bundle for the sub-band frame serializer: band capture, word output, drop reporting.
`timescale 1ns/1ps
interface subband_frame_serializer_if #(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 35,
    parameter int OUT_W  = 16
) ();
    logic                     clk_enable;
    logic                     in_valid;
    logic [NUM_CH*IN_W-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic [3:0]               out_ch;
    logic                     out_last;
    logic                     overflow;
    logic                     clear_ovf;
    logic [7:0]               drop_count;

    modport slave (
        input  clk_enable, in_valid, in_data, out_ready, clear_ovf,
        output out_valid, out_data, out_ch, out_last, overflow, drop_count
    );

    modport master (
        output clk_enable, in_valid, in_data, out_ready, clear_ovf,
        input  out_valid, out_data, out_ch, out_last, overflow, drop_count
    );
endinterface

// File: rtl/subband_frame_serializer.sv
// Rounds/saturates 16 bands to sfix16_En13 into a ping-pong buffer and streams them in band order.
// First word valid one edge after the capture edge; a stalled word holds, a capture with no free slot is dropped and counted.
`timescale 1ns/1ps
module subband_frame_serializer #(
    parameter int NUM_CH = 16,
    parameter int IN_W   = 35,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 19
) (
    input  logic                      clock,
    input  logic                      reset,
    subband_frame_serializer_if.slave bus
);
    typedef enum logic {IDLE, SEND} state_t;

    localparam logic [3:0]    LAST_CH = 4'(NUM_CH - 1);
    localparam logic [IN_W:0] HALF    = (IN_W + 1)'(1) << (SHIFT - 1);

    // Round half toward +inf on the sign-extended sample, then clamp to OUT_W.
    function automatic logic [OUT_W-1:0] quantize(input logic [IN_W-1:0] x);
        logic [IN_W:0]       t;
        logic [IN_W-SHIFT:0] q;
        t = {x[IN_W-1], x} + HALF;
        q = t[IN_W:SHIFT];
        if (!q[IN_W-SHIFT] && (|q[IN_W-SHIFT-1:OUT_W-1]))
            return {1'b0, {(OUT_W-1){1'b1}}};
        else if (q[IN_W-SHIFT] && !(&q[IN_W-SHIFT-1:OUT_W-1]))
            return {1'b1, {(OUT_W-1){1'b0}}};
        return q[OUT_W-1:0];
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [3:0]       rd_ch_q, rd_ch_d;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [3:0]       out_ch_q;
    logic             out_last_q;
    logic             overflow_q;
    logic [7:0]       drop_count_q;

    logic [OUT_W-1:0] slot_q [2][NUM_CH];
    logic [OUT_W-1:0] quant  [NUM_CH];

    logic capture, xfer, last_xfer, accept, drop;

    assign capture   = bus.in_valid & bus.clk_enable;
    assign xfer      = out_valid_q & bus.out_ready;
    assign last_xfer = xfer && (rd_ch_q == LAST_CH);
    // The write slot may be the one whose last word leaves on this very edge.
    assign accept    = capture && (!full_q[wr_sel_q] || (last_xfer && (rd_sel_q == wr_sel_q)));
    assign drop      = capture && !accept;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++)
            quant[k] = quantize(bus.in_data[k*IN_W +: IN_W]);
    end

    always_comb begin
        state_d  = state_q;
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        rd_ch_d  = rd_ch_q;
        if (state_q == IDLE) begin
            if (|full_q)
                state_d = SEND;
        end else if (xfer) begin
            if (last_xfer) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
                rd_ch_d          = '0;
                if (!full_q[!rd_sel_q])
                    state_d = IDLE;
            end else begin
                rd_ch_d = rd_ch_q + 4'd1;
            end
        end
        if (accept) begin
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
        end
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            for (int k = 0; k < NUM_CH; k++)
                slot_q[wr_sel_q][k] <= quant[k];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            full_q       <= '0;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            rd_ch_q      <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_last_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            wr_sel_q    <= wr_sel_d;
            rd_sel_q    <= rd_sel_d;
            rd_ch_q     <= rd_ch_d;
            out_valid_q <= (state_d == SEND);
            out_ch_q    <= rd_ch_d;
            out_last_q  <= (state_d == SEND) && (rd_ch_d == LAST_CH);
            out_data_q  <= (state_d == SEND) ? slot_q[rd_sel_d][rd_ch_d] : '0;
            if (bus.clear_ovf) begin
                overflow_q   <= 1'b0;
                drop_count_q <= '0;
            end else if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 8'hFF)
                    drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_last   = out_last_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;
endmodule
